// File: rtl/baccarat_datapath.sv
// Baccarat card-holding datapath: six hand slots, scores, sticky errors.
// Latency: a card is stored on its strobe edge; cards/scores are valid the next cycle.
// Backpressure: none. Illegal strobes are dropped and flagged in err. Build option: CARD_LFSR_EN.
module baccarat_datapath #(
  parameter int DECK_MAX  = 13,
  parameter int ZERO_FROM = 10
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       use_ext_card,
  input  logic [3:0] card_in,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic [1:0] err
);

  // Slot order: 0..2 = player 1..3, 3..5 = dealer 1..3.
  logic [5:0][3:0] slot_q, slot_d;
  logic [2:0]      cards_dealt_q, cards_dealt_d;
  logic [1:0]      err_q, err_d;
  logic [3:0]      src_card;
  logic [3:0]      draw;
  logic [5:0]      strobes;
  logic            multi_load;
  logic            any_load;
  logic            card_legal;
  logic [2:0]      sel;

`ifdef CARD_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_mod;

  // LFSR source: taps 8,6,5,4, shifted left every cycle; it never reaches 0.
  always_comb begin
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    lfsr_mod = lfsr_q % 8'(DECK_MAX);
    src_card = lfsr_mod[3:0] + 4'd1;
  end

  // LFSR state register, seeded on reset.
  always_ff @(posedge slow_clock) begin
    if (resetb) lfsr_q <= 8'h01;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic [3:0] src_card_q, src_card_d;

  // Counter source: 1..DECK_MAX wrapping, advancing every cycle regardless of loads.
  always_comb begin
    src_card_d = (src_card_q == 4'(DECK_MAX)) ? 4'd1 : src_card_q + 4'd1;
    src_card   = src_card_q;
  end

  // Counter source register, seeded on reset.
  always_ff @(posedge slow_clock) begin
    if (resetb) src_card_q <= 4'd1;
    else        src_card_q <= src_card_d;
  end
`endif

  // Strobe decode, draw selection and the load/error rules.
  always_comb begin
    strobes    = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};
    any_load   = |strobes;
    // More than one bit set iff clearing the lowest set bit leaves something.
    multi_load = |(strobes & (strobes - 6'd1));
    draw       = use_ext_card ? card_in : src_card;
    card_legal = !use_ext_card || ((card_in != 4'd0) && (card_in <= 4'(DECK_MAX)));

    sel = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (strobes[i]) sel = 3'(i);
    end

    slot_d        = slot_q;
    cards_dealt_d = cards_dealt_q;
    err_d         = err_q;

    if (multi_load) begin
      err_d[0] = 1'b1;
    end else if (any_load) begin
      // A full slot or a bad injected card is dropped; a 7th load always lands here.
      if (!card_legal || (slot_q[sel] != 4'd0)) begin
        err_d[1] = 1'b1;
      end else begin
        slot_d[sel]   = draw;
        cards_dealt_d = cards_dealt_q + 3'd1;
      end
    end
  end

  // Slot, count and error registers; reset overrides any strobe in the same cycle.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      slot_q        <= '0;
      cards_dealt_q <= 3'd0;
      err_q         <= 2'b00;
    end else begin
      slot_q        <= slot_d;
      cards_dealt_q <= cards_dealt_d;
      err_q         <= err_d;
    end
  end

  function automatic logic [4:0] card_val(input logic [3:0] r);
    if ((r == 4'd0) || (r >= 4'(ZERO_FROM))) card_val = 5'd0;
    else                                      card_val = {1'b0, r};
  endfunction

  logic [4:0] psum, dsum, pmod, dmod;

  // Hand scores: 5-bit sum (max 27) reduced mod 10; pcard3 stays the raw rank.
  always_comb begin
    psum   = card_val(slot_q[0]) + card_val(slot_q[1]) + card_val(slot_q[2]);
    dsum   = card_val(slot_q[3]) + card_val(slot_q[4]) + card_val(slot_q[5]);
    pmod   = psum % 5'd10;
    dmod   = dsum % 5'd10;
    pscore = pmod[3:0];
    dscore = dmod[3:0];
  end

  assign pcard1      = slot_q[0];
  assign pcard2      = slot_q[1];
  assign pcard3      = slot_q[2];
  assign dcard1      = slot_q[3];
  assign dcard2      = slot_q[4];
  assign dcard3      = slot_q[5];
  assign cards_dealt = cards_dealt_q;
  assign err         = err_q;

endmodule

// File: doc/baccarat_datapath.md
Name: baccarat_datapath

Overview:
- Card-holding datapath beside the baccarat round controller.
- Consumes the controller's six load strobes, draws a card value on each strobe, and stores it in one of six hand slots (player 1-3, dealer 1-3).
- Returns pscore, dscore and pcard3 to the controller, and the six card values to the display logic.
- The internal card source advances every cycle; an external card-injection path exists for test and demo.

Parameters:
- DECK_MAX, 13: highest card rank; ranks run 1..DECK_MAX (1=A, 11=J, 12=Q, 13=K).
- ZERO_FROM, 10: ranks >= ZERO_FROM score 0; ranks below score their face value.

Ports:
- slow_clock  in  1  sole clock; all state updates on its rising edge.
- resetb  in  1  synchronous, active-high reset (the name is the codebase convention; polarity is high).
- load_pcard1, load_pcard2, load_pcard3  in  1 each  load strobes for player slots 1-3.
- load_dcard1, load_dcard2, load_dcard3  in  1 each  load strobes for dealer slots 1-3.
- use_ext_card  in  1  1 = take the card value from card_in instead of the internal source.
- card_in  in  4  external card rank, legal range 1..DECK_MAX.
- pcard1, pcard2, pcard3  out  4 each  stored player card ranks; 0 = slot empty.
- dcard1, dcard2, dcard3  out  4 each  stored dealer card ranks; 0 = slot empty.
- pscore, dscore  out  4 each  hand scores, 0..9.
- cards_dealt  out  3  number of occupied slots, 0..6.
- err  out  2  sticky errors: bit0 = multi-load, bit1 = reload/illegal card.

Behaviour:
- Synchronous, active-high reset. On a rising edge with resetb=1:
  - all six slots = 0, cards_dealt = 0, err = 0;
  - the card source returns to its seed;
  - load strobes in the same cycle are ignored.
- Card source (default build):
  - src_card register; reset value 1.
  - Advances every cycle: 1, 2, ..., DECK_MAX, then wraps to 1.
  - Advances regardless of loads.
- Drawn value:
  - draw = card_in when use_ext_card=1, else src_card, sampled in the same cycle as the strobe.
  - card_in = 0 or card_in > DECK_MAX with use_ext_card=1 and a valid single strobe: the load is suppressed and err[1] is set.
- Load rules, evaluated each non-reset edge:
  - Exactly one strobe high and its slot empty: the slot takes draw on that edge; cards_dealt increments by 1.
  - Exactly one strobe high and its slot non-zero: no write, cards_dealt unchanged, err[1] set.
  - Two or more strobes high: no slot is written, err[0] set.
  - No strobe high: slots hold.
- Latency:
  - A card is stored on the edge where its strobe is sampled.
  - pscore, dscore and all pcardN/dcardN are combinational from slot registers, so they are valid the cycle after the strobe.
  - No other pipeline delay.
- Score arithmetic:
  - val(r) = 0 if r=0 or r >= ZERO_FROM, else r.
  - pscore = (val(p1)+val(p2)+val(p3)) mod 10; dscore is the same over the dealer slots.
  - Use a 5-bit intermediate sum (maximum 27) before the mod.
- pcard3 output is the raw rank, not val; the controller applies its own rules to it.
- Errors are sticky until reset and never block later legal loads.
- Reset asserted mid-round: it wins over any strobe in the same cycle, and the next round starts clean.
- cards_dealt never exceeds 6; it saturates structurally because a 7th load is always a reload error.

Optional Feature:
- CARD_LFSR_EN defined: the card source is an 8-bit Fibonacci LFSR.
  - Taps 8,6,5,4; shifts left every cycle; feedback into bit0; seed 8'h01 on reset.
  - src_card = (lfsr mod DECK_MAX) + 1.
  - The LFSR never reaches 0.
- CARD_LFSR_EN undefined: the 1..DECK_MAX wrapping counter above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, use_ext_card=1, then load p1=3, d1=13, p2=4, d2=5, one strobe per cycle -> pscore=7, dscore=5, cards_dealt=4, err=0.
- Internal source, default build: reset, hold idle 4 cycles, then pulse load_pcard1 -> pcard1=5. After 13 more idle cycles, pulse load_dcard1 -> dcard1 = previous source value + 1 with wrap 13->1 exercised.
- Ext cards p1=9, p2=9, p3=9 -> pscore=7, proving mod 10 on sum 27. p1=10, p2=12 -> pscore=0.
- Pulse load_pcard1 and load_dcard1 together -> no slot written, err=2'b01, cards_dealt unchanged. A following single legal load still succeeds.
- Pulse load_pcard2 twice, and ext card_in=0 on load_dcard3 -> the second pcard2 load and the dcard3 load are both dropped, err[1]=1. Also assert resetb together with load_dcard2 -> all slots 0, err=0.
- CARD_LFSR_EN build: after reset the first 8 drawn values match the reference LFSR model, all lie in 1..13, and none is 0.
